// File: rtl/kbd_pkg.sv
// Shared constants, FSM state type and frame check helper for the PS/2 keyboard receiver.
`timescale 1ns/1ps
package kbd_pkg;

    localparam int unsigned PS2_FRAME_BITS         = 11;
    localparam int unsigned PS2_DATA_BITS          = 8;
    localparam int unsigned FIFO_DEPTH_DEFAULT     = 8;
    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 200000;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } ps2_state_e;

    // Odd parity over data+parity, and the stop bit must be high.
    function automatic logic frame_valid(input logic [PS2_DATA_BITS-1:0] data,
                                         input logic parity,
                                         input logic stop);
        return stop & (^{data, parity});
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; reports which push/pop requests were accepted.
`timescale 1ns/1ps
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    output logic [WIDTH-1:0]           head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       push_ok_o,
    output logic                       pop_ok_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;

    always_comb begin
        empty_o   = (wr_ptr_q == rd_ptr_q);
        full_o    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        count_o   = wr_ptr_q - rd_ptr_q;
        pop_ok_o  = pop_i & ~empty_o;
        // A pop in the same cycle frees the slot a full FIFO needs.
        push_ok_o = push_i & (~full_o | pop_ok_o);
        head_o    = mem_q[rd_ptr_q[AW-1:0]];
        wr_ptr_d  = push_ok_o ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = pop_ok_o  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok_o) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 device-to-host frame receiver: synchroniser, fall detect, frame FSM with timeout,
// byte FIFO and sticky overflow flag.
`timescale 1ns/1ps
module ps2_kbd_rx
    import kbd_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = FIFO_DEPTH_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    input  logic       kbd_read_enable_i,
    output logic [7:0] kbd_data_o,
    output logic       kbd_ready_o,
    output logic       kbd_overflow_o,
    output logic       rx_error_o
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic ps2_clk_s1_q, ps2_clk_s2_q, ps2_clk_prev_q;
    logic ps2_data_s1_q, ps2_data_s2_q;
    logic fall;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ps2_clk_s1_q   <= 1'b1;
            ps2_clk_s2_q   <= 1'b1;
            ps2_clk_prev_q <= 1'b1;
            ps2_data_s1_q  <= 1'b1;
            ps2_data_s2_q  <= 1'b1;
        end else begin
            ps2_clk_s1_q   <= ps2_clk_i;
            ps2_clk_s2_q   <= ps2_clk_s1_q;
            ps2_clk_prev_q <= ps2_clk_s2_q;
            ps2_data_s1_q  <= ps2_data_i;
            ps2_data_s2_q  <= ps2_data_s1_q;
        end
    end

    assign fall = ps2_clk_prev_q & ~ps2_clk_s2_q;

    ps2_state_e        state_q;
    logic [2:0]        bit_cnt_q;
    logic [7:0]        shift_q;
    logic              parity_q;
    logic              rx_error_q;
    logic [TW-1:0]     tmo_q;
    logic              frame_ok;

    assign frame_ok = frame_valid(shift_q, parity_q, ps2_data_s2_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            rx_error_q <= 1'b0;
            tmo_q      <= '0;
        end else begin
            rx_error_q <= 1'b0;
            tmo_q      <= (state_q == StIdle || fall) ? '0 : tmo_q + 1'b1;
            if (fall) begin
                unique case (state_q)
                    StIdle: begin
                        if (!ps2_data_s2_q) begin
                            state_q   <= StData;
                            bit_cnt_q <= '0;
                        end else begin
                            rx_error_q <= 1'b1;
                        end
                    end
                    StData: begin
                        shift_q   <= {ps2_data_s2_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= StParity;
                        end
                    end
                    StParity: begin
                        parity_q <= ps2_data_s2_q;
                        state_q  <= StStop;
                    end
                    StStop: begin
                        state_q <= StIdle;
                        if (!frame_ok) begin
                            rx_error_q <= 1'b1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end else if (state_q != StIdle && tmo_q == TMO_LAST) begin
                state_q    <= StIdle;
                rx_error_q <= 1'b1;
            end
        end
    end

    logic          push;
    logic          fifo_full, fifo_empty, push_ok, pop_ok;
    logic [7:0]    fifo_head;
    logic [CW-1:0] fifo_count;
    logic          overflow_q;

    assign push = fall & (state_q == StStop) & frame_ok;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push_i    (push),
        .pop_i     (kbd_read_enable_i),
        .wr_data_i (shift_q),
        .head_o    (fifo_head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count),
        .push_ok_o (push_ok),
        .pop_ok_o  (pop_ok)
    );

    // Set has priority; clear only when the last byte leaves.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overflow_q <= 1'b0;
        end else if (push & fifo_full & ~pop_ok) begin
            overflow_q <= 1'b1;
        end else if (pop_ok & ~push_ok & (fifo_count == CW'(1))) begin
            overflow_q <= 1'b0;
        end
    end

    assign kbd_data_o     = fifo_empty ? 8'h00 : fifo_head;
    assign kbd_ready_o    = ~fifo_empty;
    assign kbd_overflow_o = overflow_q;
    assign rx_error_o     = rx_error_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Self-checking bench: PS/2 device model, vector table, corner sequences and a queue-based model.
`timescale 1ns/1ps
module tb_ps2_kbd_rx;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned TMO   = 2000;
    localparam int unsigned HALF  = 20;  // 500 kHz clk -> 12.5 kHz PS/2 clock

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk, ps2_data, rd_en;
    logic [7:0] kbd_data;
    logic       kbd_ready, kbd_ovf, rx_error;

    always #1000 clk = ~clk;

    ps2_kbd_rx #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .ps2_clk_i         (ps2_clk),
        .ps2_data_i        (ps2_data),
        .kbd_read_enable_i (rd_en),
        .kbd_data_o        (kbd_data),
        .kbd_ready_o       (kbd_ready),
        .kbd_overflow_o    (kbd_ovf),
        .rx_error_o        (rx_error)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int err_cnt  = 0;

    always @(negedge clk) if (rx_error === 1'b1) err_cnt++;

    initial begin
        #(64'd400_000_000);
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, got, exp);
    endtask

    // Reference model: byte queue, sticky overflow, error count.
    logic [7:0] model_q[$];
    bit         model_ovf;
    int         model_err;

    task automatic model_frame(input logic [7:0] d, input bit ok);
        if (!ok) model_err++;
        else if (model_q.size() < DEPTH) model_q.push_back(d);
        else model_ovf = 1'b1;
    endtask

    task automatic model_pop();
        if (model_q.size() > 0) begin
            void'(model_q.pop_front());
            if (model_q.size() == 0) model_ovf = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic pop();
        @(negedge clk) rd_en = 1'b1;
        @(negedge clk) rd_en = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par_flip, input bit stop,
                              input bit pop_at_push, input int nbits,
                              output bit r2, output bit r4);
        logic [10:0] f;
        f  = {stop, (~^d) ^ par_flip, d, 1'b0};
        r2 = 1'b0;
        r4 = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            for (int k = 1; k <= int'(HALF); k++) begin
                @(negedge clk);
                if (i == 10) begin
                    if (k == 2) r2 = kbd_ready;
                    if (k == 4) r4 = kbd_ready;
                    rd_en = pop_at_push && (k == 2);
                end
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    typedef struct {
        bit         send;
        logic [7:0] d;
        bit         par_flip;
        bit         stop;
        int         pops;
        bit         exp_ready;
        logic [7:0] exp_data;
        bit         exp_ovf;
        int         exp_err;
        string      name;
    } vec_t;

    vec_t tbl[$];

    initial begin
        bit r2, r4;
        int e0;
        rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; rd_en = 1'b0;

        do_reset();
        check("rst_ready", kbd_ready, 0);
        check("rst_data", kbd_data, 8'h00);
        check("rst_ovf", kbd_ovf, 0);
        check("rst_err", rx_error, 0);

        // Single frame latency from stop fall, then pop.
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 11, r2, r4);
        check("lat_early", r2, 0);
        check("lat_ready", r4, 1);
        check("f1_data", kbd_data, 8'h1C);
        pop();
        check("f1_pop_ready", kbd_ready, 0);
        check("f1_pop_data", kbd_data, 8'h00);

        tbl.push_back('{1'b1, 8'hF0, 1'b0, 1'b1, 0, 1'b1, 8'hF0, 1'b0, 0, "f0"});
        tbl.push_back('{1'b1, 8'h1C, 1'b0, 1'b1, 0, 1'b1, 8'hF0, 1'b0, 0, "f0_1c"});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1, 1'b1, 8'h1C, 1'b0, 0, "pop_f0"});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1, 1'b0, 8'h00, 1'b0, 0, "pop_1c"});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1, 1'b0, 8'h00, 1'b0, 0, "pop_empty"});
        tbl.push_back('{1'b1, 8'h1C, 1'b1, 1'b1, 0, 1'b0, 8'h00, 1'b0, 1, "bad_par"});
        tbl.push_back('{1'b1, 8'h1C, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1, "bad_stop"});
        for (int i = 1; i <= 9; i++)
            tbl.push_back('{1'b1, 8'(i), 1'b0, 1'b1, 0, 1'b1, 8'h01, (i == 9), 0, "fill"});
        for (int k = 1; k <= 8; k++)
            tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1, (k < 8), (k < 8) ? 8'(k + 1) : 8'h00,
                            (k < 8), 0, "drain"});

        foreach (tbl[i]) begin
            e0 = err_cnt;
            if (tbl[i].send) send_frame(tbl[i].d, tbl[i].par_flip, tbl[i].stop, 1'b0, 11, r2, r4);
            for (int p = 0; p < tbl[i].pops; p++) pop();
            check({tbl[i].name, "_ready"}, kbd_ready, tbl[i].exp_ready);
            check({tbl[i].name, "_data"}, kbd_data, tbl[i].exp_data);
            check({tbl[i].name, "_ovf"}, kbd_ovf, tbl[i].exp_ovf);
            check({tbl[i].name, "_err"}, err_cnt - e0, tbl[i].exp_err);
        end

        // Full FIFO with a pop in the push cycle of 0x0A.
        do_reset();
        for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b0, 1'b1, 1'b0, 11, r2, r4);
        send_frame(8'h0A, 1'b0, 1'b1, 1'b1, 11, r2, r4);
        check("pp_ovf", kbd_ovf, 0);
        for (int i = 0; i < 8; i++) begin
            check("pp_head", kbd_data, (i < 7) ? i + 2 : 8'h0A);
            pop();
        end
        check("pp_empty", kbd_ready, 0);

        // Truncated frame -> timeout, then a clean frame.
        do_reset();
        e0 = err_cnt;
        send_frame(8'h55, 1'b0, 1'b1, 1'b0, 5, r2, r4);
        repeat (1500) @(negedge clk);
        check("tmo_early", err_cnt - e0, 0);
        repeat (700) @(negedge clk);
        check("tmo_fire", err_cnt - e0, 1);
        check("tmo_ready", kbd_ready, 0);
        send_frame(8'h29, 1'b0, 1'b1, 1'b0, 11, r2, r4);
        check("tmo_next_ready", kbd_ready, 1);
        check("tmo_next_data", kbd_data, 8'h29);
        check("tmo_next_err", err_cnt - e0, 1);

        // Overflow set, then reset mid-frame clears everything.
        for (int i = 0; i < 9; i++) send_frame(8'h30 + 8'(i), 1'b0, 1'b1, 1'b0, 11, r2, r4);
        check("pre_rst_ovf", kbd_ovf, 1);
        send_frame(8'h77, 1'b0, 1'b1, 1'b0, 4, r2, r4);
        do_reset();
        check("mid_rst_ready", kbd_ready, 0);
        check("mid_rst_data", kbd_data, 8'h00);
        check("mid_rst_ovf", kbd_ovf, 0);
        check("mid_rst_err", rx_error, 0);
        e0 = err_cnt;
        send_frame(8'h29, 1'b0, 1'b1, 1'b0, 11, r2, r4);
        check("rst_next_data", kbd_data, 8'h29);
        check("rst_next_err", err_cnt - e0, 0);

        // Randomized frames and pops against the queue model.
        do_reset();
        model_q.delete();
        model_ovf = 1'b0;
        model_err = 0;
        e0 = err_cnt;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 9) < 3) begin
                pop();
                model_pop();
            end else begin
                logic [7:0] d;
                int         kind;
                d    = 8'($urandom);
                kind = $urandom_range(0, 7);
                send_frame(d, kind == 0, kind != 1, 1'b0, 11, r2, r4);
                model_frame(d, kind > 1);
            end
            check("rnd_ready", kbd_ready, model_q.size() > 0);
            check("rnd_data", kbd_data, (model_q.size() > 0) ? model_q[0] : 8'h00);
            check("rnd_ovf", kbd_ovf, model_ovf);
            check("rnd_err", err_cnt - e0, model_err);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
